// File: rtl/uart_tx_fifo.sv
// UART transmitter fed by a circular transmit FIFO; queued words leave back-to-back
// with a configurable frame (data width, optional parity, one or two stop bits).
module uart_tx_fifo #(
  parameter int CLK        = 50_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_W     = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [DATA_W-1:0]             data_in,
  input  logic                          flag_in,
  output logic                          fifo_full,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          overflow,
  output logic                          tx_busy,
  output logic                          UART_tx
);

  localparam int BAUD_CNT = CLK / BAUD;
  localparam int PTR_W    = $clog2(FIFO_DEPTH);
  localparam int LVL_W    = PTR_W + 1;
  localparam int CNT_W    = (BAUD_CNT > 2) ? $clog2(BAUD_CNT) : 1;

  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(BAUD_CNT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [2:0]       DATA_LAST = 3'(DATA_W - 1);
  localparam logic [2:0]       STOP_LAST = 3'(STOP_BITS - 1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [LVL_W-1:0] LVL_ONE   = LVL_W'(1);
  localparam logic [LVL_W-1:0] LVL_ZERO  = LVL_W'(0);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] START = 3'd1;
  localparam logic [2:0] DATA  = 3'd2;
  localparam logic [2:0] PAR   = 3'd3;
  localparam logic [2:0] STOP  = 3'd4;

  function automatic logic calc_parity(input logic [DATA_W-1:0] word);
    if (PARITY == 1) begin
      calc_parity = ~(^word);
    end else begin
      calc_parity = ^word;
    end
  endfunction

  logic [DATA_W-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r, rd_ptr_r;
  logic [LVL_W-1:0]  level_r, level_nxt_s;
  logic              full_r, overflow_r;
  logic [2:0]        state_r, bit_cnt_r;
  logic [CNT_W-1:0]  baud_cnt_r;
  logic [DATA_W-1:0] shift_r, head_s;
  logic              par_r, tx_r, busy_r;
  logic              push_s, pop_s, nonempty_s, baud_last_s;

  assign push_s      = flag_in && !full_r;
  assign nonempty_s  = (level_r != LVL_ZERO);
  assign baud_last_s = (baud_cnt_r == BAUD_LAST);
  assign head_s      = mem_r[rd_ptr_r];

  assign fifo_full  = full_r;
  assign fifo_level = level_r;
  assign overflow   = overflow_r;
  assign tx_busy    = busy_r;
  assign UART_tx    = tx_r;

  // Pop on leaving IDLE or at the final stop-bit cycle, so queued frames abut.
  always_comb begin
    pop_s = 1'b0;
    case (state_r)
      IDLE:    pop_s = nonempty_s;
      STOP:    pop_s = baud_last_s && (bit_cnt_r == STOP_LAST) && nonempty_s;
      default: pop_s = 1'b0;
    endcase
  end

  // Next occupancy; a simultaneous push and pop leaves it unchanged.
  always_comb begin
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LVL_ONE;
      2'b01:   level_nxt_s = level_r - LVL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // FIFO storage write port.
  always_ff @(posedge clk) begin
    if (rst_n && push_s) begin
      mem_r[wr_ptr_r] <= data_in;
    end
  end

  // FIFO pointers, occupancy flags and drop reporting.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      level_r    <= LVL_ZERO;
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
      level_r    <= level_nxt_s;
      full_r     <= (level_nxt_s == LVL_FULL);
      overflow_r <= flag_in && full_r;
    end
  end

  // Frame serialiser; the line register is updated on the same edge as the state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      baud_cnt_r <= CNT_ZERO;
      bit_cnt_r  <= 3'd0;
      shift_r    <= {DATA_W{1'b0}};
      par_r      <= 1'b0;
      tx_r       <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          baud_cnt_r <= CNT_ZERO;
          bit_cnt_r  <= 3'd0;
          if (pop_s) begin
            state_r <= START;
            shift_r <= head_s;
            par_r   <= calc_parity(head_s);
            tx_r    <= 1'b0;
            busy_r  <= 1'b1;
          end else begin
            tx_r   <= 1'b1;
            busy_r <= 1'b0;
          end
        end
        START: begin
          if (baud_last_s) begin
            baud_cnt_r <= CNT_ZERO;
            bit_cnt_r  <= 3'd0;
            state_r    <= DATA;
            tx_r       <= shift_r[0];
            shift_r    <= {1'b0, shift_r[DATA_W-1:1]};
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end
        DATA: begin
          if (baud_last_s) begin
            baud_cnt_r <= CNT_ZERO;
            if (bit_cnt_r == DATA_LAST) begin
              bit_cnt_r <= 3'd0;
              if (PARITY != 0) begin
                state_r <= PAR;
                tx_r    <= par_r;
              end else begin
                state_r <= STOP;
                tx_r    <= 1'b1;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
              tx_r      <= shift_r[0];
              shift_r   <= {1'b0, shift_r[DATA_W-1:1]};
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end
        PAR: begin
          if (baud_last_s) begin
            baud_cnt_r <= CNT_ZERO;
            bit_cnt_r  <= 3'd0;
            state_r    <= STOP;
            tx_r       <= 1'b1;
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end
        STOP: begin
          if (baud_last_s) begin
            baud_cnt_r <= CNT_ZERO;
            if (bit_cnt_r == STOP_LAST) begin
              bit_cnt_r <= 3'd0;
              if (pop_s) begin
                state_r <= START;
                shift_r <= head_s;
                par_r   <= calc_parity(head_s);
                tx_r    <= 1'b0;
              end else begin
                state_r <= IDLE;
                tx_r    <= 1'b1;
                busy_r  <= 1'b0;
              end
            end else begin
              bit_cnt_r <= bit_cnt_r + 3'd1;
            end
          end else begin
            baud_cnt_r <= baud_cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r    <= IDLE;
          baud_cnt_r <= CNT_ZERO;
          bit_cnt_r  <= 3'd0;
          tx_r       <= 1'b1;
          busy_r     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: default-rate, fast 8N1 and 7-bit parity/two-stop instances,
// with a serial decoder feeding a word scoreboard.
module tb_uart_tx_fifo;

  localparam int BC_A = 434;
  localparam int BC_B = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_rst_n, a_flag, a_full, a_ovf, a_busy, a_tx;
  logic [7:0] a_data;
  logic [3:0] a_level;
  logic       b_rst_n, b_flag, b_full, b_ovf, b_busy, b_tx;
  logic [7:0] b_data;
  logic [3:0] b_level;
  logic       cd_rst_n, cd_flag;
  logic [6:0] cd_data;
  logic       c_full, c_ovf, c_busy, c_tx, d_full, d_ovf, d_busy, d_tx;
  logic [3:0] c_level, d_level;

  uart_tx_fifo #(.CLK(50_000_000), .BAUD(115_200), .DATA_W(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8)) u_a (
    .clk(clk), .rst_n(a_rst_n), .data_in(a_data), .flag_in(a_flag), .fifo_full(a_full),
    .fifo_level(a_level), .overflow(a_ovf), .tx_busy(a_busy), .UART_tx(a_tx));
  uart_tx_fifo #(.CLK(400), .BAUD(100), .DATA_W(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(8)) u_b (
    .clk(clk), .rst_n(b_rst_n), .data_in(b_data), .flag_in(b_flag), .fifo_full(b_full),
    .fifo_level(b_level), .overflow(b_ovf), .tx_busy(b_busy), .UART_tx(b_tx));
  uart_tx_fifo #(.CLK(400), .BAUD(100), .DATA_W(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(8)) u_c (
    .clk(clk), .rst_n(cd_rst_n), .data_in(cd_data), .flag_in(cd_flag), .fifo_full(c_full),
    .fifo_level(c_level), .overflow(c_ovf), .tx_busy(c_busy), .UART_tx(c_tx));
  uart_tx_fifo #(.CLK(400), .BAUD(100), .DATA_W(7), .PARITY(1), .STOP_BITS(2), .FIFO_DEPTH(8)) u_d (
    .clk(clk), .rst_n(cd_rst_n), .data_in(cd_data), .flag_in(cd_flag), .fifo_full(d_full),
    .fifo_level(d_level), .overflow(d_ovf), .tx_busy(d_busy), .UART_tx(d_tx));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", name, act, exp);
    end
  endtask

  // Serial decoder state for the two 8N1 instances (0 = u_a, 1 = u_b).
  bit         mon_act [2];
  int         mon_pos [2];
  logic [7:0] mon_byte [2];
  int         frames [2];
  logic [7:0] qa[$], qb[$];
  longint     starts_a[$], starts_b[$];
  longint     cyc = 0;
  int         ovf_a = 0, ovf_b = 0;

  task automatic mon_step(input int m, input logic line, input logic rst, input int bc);
    int k;
    int qsize;
    logic [7:0] exp_b;
    if (!rst) begin
      mon_act[m] = 1'b0;
    end else begin
      if (!mon_act[m] && line == 1'b0) begin
        mon_act[m] = 1'b1;
        mon_pos[m] = 0;
        if (m == 0) starts_a.push_back(cyc); else starts_b.push_back(cyc);
      end
      if (mon_act[m]) begin
        if (mon_pos[m] % bc == bc / 2) begin
          k = mon_pos[m] / bc;
          if (k == 0) check($sformatf("start_bit%0d", m), 64'(line), 64'(0));
          else if (k <= 8) mon_byte[m][k-1] = line;
          else check($sformatf("stop_bit%0d", m), 64'(line), 64'(1));
        end
        if (mon_pos[m] == 10 * bc - 1) begin
          frames[m]++;
          mon_act[m] = 1'b0;
          qsize = (m == 0) ? qa.size() : qb.size();
          check($sformatf("frame_was_queued%0d", m), 64'(qsize > 0), 64'(1));
          if (qsize > 0) begin
            exp_b = (m == 0) ? qa.pop_front() : qb.pop_front();
            check($sformatf("rx_byte%0d", m), 64'(mon_byte[m]), 64'(exp_b));
          end
        end else begin
          mon_pos[m]++;
        end
      end
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (a_ovf) ovf_a++;
      if (b_ovf) ovf_b++;
      mon_step(0, a_tx, a_rst_n, BC_A);
      mon_step(1, b_tx, b_rst_n, BC_B);
    end
  end

  typedef struct {
    logic [6:0] data;
    logic       par_even;
    logic       par_odd;
  } pvec_t;

  function automatic logic [47:0] build_frame(input logic [6:0] d, input logic p);
    logic [47:0] f;
    int b;
    for (int k = 0; k < 48; k++) begin
      b = k / 4;
      if (k >= 44)     f[k] = 1'b1;
      else if (b == 0) f[k] = 1'b0;
      else if (b <= 7) f[k] = d[b-1];
      else if (b == 8) f[k] = p;
      else             f[k] = 1'b1;
    end
    return f;
  endfunction

  initial begin
    pvec_t       pv [4];
    logic [7:0]  burst [8];
    logic [47:0] cap_c, cap_d, cap_b, bz_b;
    logic [10:0] full_s, ovf_s;
    logic [3:0]  peak;
    int hc, hd, hi, lows, busy_len, fb0, ob0, bad;

    pv[0] = '{7'h55, 1'b0, 1'b1};
    pv[1] = '{7'h54, 1'b1, 1'b0};
    pv[2] = '{7'h7F, 1'b1, 1'b0};
    pv[3] = '{7'h00, 1'b0, 1'b1};
    burst = '{8'h10, 8'h21, 8'h32, 8'h43, 8'h54, 8'h65, 8'h76, 8'h87};

    a_rst_n = 1'b0; b_rst_n = 1'b0; cd_rst_n = 1'b0;
    a_flag = 1'b0; b_flag = 1'b0; cd_flag = 1'b0;
    a_data = 8'h00; b_data = 8'h00; cd_data = 7'h00;
    repeat (3) @(negedge clk);
    check("rst_tx",    64'({a_tx, b_tx, c_tx, d_tx}), 64'(4'hF));
    check("rst_busy",  64'({a_busy, b_busy, c_busy, d_busy}), 64'(0));
    check("rst_full",  64'({a_full, b_full, c_full, d_full}), 64'(0));
    check("rst_ovf",   64'({a_ovf, b_ovf, c_ovf, d_ovf}), 64'(0));
    check("rst_level", 64'({a_level, b_level, c_level, d_level}), 64'(0));
    a_rst_n = 1'b1; b_rst_n = 1'b1; cd_rst_n = 1'b1;
    @(negedge clk);

    // Parity / two stop bits, table driven on the 7-bit even and odd instances.
    for (int v = 0; v < 4; v++) begin
      cd_data = pv[v].data;
      cd_flag = 1'b1;
      @(negedge clk);
      cd_flag = 1'b0;
      hc = 0; hd = 0;
      for (int k = 0; k < 48; k++) begin
        @(negedge clk);
        cap_c[k] = c_tx;
        cap_d[k] = d_tx;
        if (c_busy) hc++;
        if (d_busy) hd++;
      end
      check($sformatf("even_par_bit_v%0d", v), 64'(cap_c[33]), 64'(pv[v].par_even));
      check($sformatf("odd_par_bit_v%0d", v),  64'(cap_d[33]), 64'(pv[v].par_odd));
      check($sformatf("even_frame_v%0d", v), 64'(cap_c), 64'(build_frame(pv[v].data, pv[v].par_even)));
      check($sformatf("odd_frame_v%0d", v),  64'(cap_d), 64'(build_frame(pv[v].data, pv[v].par_odd)));
      check($sformatf("even_len_v%0d", v), 64'(hc), 64'(44));
      check($sformatf("odd_len_v%0d", v),  64'(hd), 64'(44));
    end

    // Single default-rate word 8'h0F.
    a_data = 8'h0F; a_flag = 1'b1; qa.push_back(8'h0F);
    @(negedge clk);
    a_flag = 1'b0;
    check("t1_level_after_push", 64'(a_level), 64'(1));
    check("t1_idle_line", 64'({a_tx, a_busy}), 64'(2'b10));
    busy_len = -1; lows = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (k == 0)       check("t1_start_edge", 64'({a_tx, a_busy}), 64'(2'b01));
      if (k == 433)     check("t1_start_end", 64'(a_tx), 64'(0));
      if (k == 434)     check("t1_bit0", 64'(a_tx), 64'(1));
      if (k == 5 * 434) check("t1_bit4", 64'(a_tx), 64'(0));
      if (!a_tx) lows++;
      if (!a_busy) begin
        busy_len = k;
        break;
      end
    end
    check("t1_busy_len", 64'(busy_len), 64'(4340));
    check("t1_low_cycles", 64'(lows), 64'(2170));
    repeat (2) @(negedge clk);
    check("t1_rx_done", 64'(qa.size()), 64'(0));

    // Burst of eight words at the default rate.
    starts_a.delete();
    ob0 = ovf_a; peak = 4'd0; hi = 0;
    for (int i = 0; i < 8; i++) begin
      a_data = burst[i]; a_flag = 1'b1; qa.push_back(burst[i]);
      @(negedge clk);
      if (a_level > peak) peak = a_level;
      if (a_busy) hi++;
    end
    a_flag = 1'b0;
    for (int k = 0; k < 40000; k++) begin
      @(negedge clk);
      if (a_level > peak) peak = a_level;
      if (!a_busy) break;
      hi++;
    end
    repeat (2) @(negedge clk);
    check("t2_peak_level", 64'(peak), 64'(7));
    check("t2_busy_len", 64'(hi), 64'(34720));
    check("t2_overflow", 64'(ovf_a - ob0), 64'(0));
    check("t2_frames", 64'(starts_a.size()), 64'(8));
    for (int i = 1; i < starts_a.size(); i++)
      check($sformatf("t2_gap%0d", i), 64'(starts_a[i] - starts_a[i-1]), 64'(4340));
    check("t2_rx_done", 64'(qa.size()), 64'(0));

    // Overflow: ten pushes into the fast 8N1 instance.
    fb0 = frames[1]; ob0 = ovf_b;
    for (int i = 0; i < 10; i++) begin
      b_data = 8'hA0 + 8'(i); b_flag = 1'b1;
      if (i < 9) qb.push_back(8'hA0 + 8'(i));
      @(negedge clk);
      full_s[i] = b_full; ovf_s[i] = b_ovf;
    end
    b_flag = 1'b0;
    @(negedge clk);
    full_s[10] = b_full; ovf_s[10] = b_ovf;
    check("t3_full_before", 64'(full_s[7]), 64'(0));
    check("t3_full_after",  64'(full_s[8]), 64'(1));
    check("t3_ovf_pulse",   64'({ovf_s[10], ovf_s[9], ovf_s[8]}), 64'(3'b010));
    bad = 1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (!b_busy) begin bad = 0; break; end
    end
    check("t3_drain_timeout", 64'(bad), 64'(0));
    repeat (2) @(negedge clk);
    check("t3_frames", 64'(frames[1] - fb0), 64'(9));
    check("t3_ovf_count", 64'(ovf_b - ob0), 64'(1));
    check("t3_rx_done", 64'(qb.size()), 64'(0));

    // Push while the last frame is in its stop bit.
    starts_b.delete();
    b_data = 8'h3C; b_flag = 1'b1; qb.push_back(8'h3C);
    @(negedge clk);
    b_flag = 1'b0;
    for (int k = 0; k < 48; k++) begin
      @(negedge clk);
      cap_b[k] = b_tx; bz_b[k] = b_busy;
      if (k == 36) begin b_data = 8'hC3; b_flag = 1'b1; qb.push_back(8'hC3); end
      if (k == 37) b_flag = 1'b0;
    end
    check("t6_stop_high", 64'(cap_b[39:36]), 64'(4'hF));
    check("t6_next_start", 64'(cap_b[40]), 64'(0));
    check("t6_busy_held", 64'(bz_b[40]), 64'(1));
    repeat (50) @(negedge clk);
    check("t6_frames", 64'(starts_b.size()), 64'(2));
    if (starts_b.size() == 2) check("t6_gap", 64'(starts_b[1] - starts_b[0]), 64'(40));
    check("t6_rx_done", 64'(qb.size()), 64'(0));

    // Reset during data bit 3 of the first of three queued frames.
    for (int i = 0; i < 3; i++) begin
      b_data = 8'h5A + 8'(i); b_flag = 1'b1; qb.push_back(8'h5A + 8'(i));
      @(negedge clk);
    end
    b_flag = 1'b0;
    repeat (16) @(negedge clk);
    @(posedge clk); #2 b_rst_n = 1'b0;
    @(posedge clk); #2 b_rst_n = 1'b1;
    @(negedge clk);
    qb.delete();
    check("t5_tx", 64'(b_tx), 64'(1));
    check("t5_level_full", 64'({b_level, b_full}), 64'(0));
    check("t5_busy", 64'(b_busy), 64'(0));
    fb0 = frames[1]; lows = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (!b_tx || b_busy) lows++;
    end
    check("t5_quiet_line", 64'(lows), 64'(0));
    check("t5_no_frames", 64'(frames[1] - fb0), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
